// File: rtl/mux_n_skid.sv
// N-way select feeding a 2-entry skid buffer with valid/ready handshake and synchronous flush.
// Optional sticky out-of-range select flag: define MUX_N_SKID_SEL_CHECK_EN to add sel_err.
module mux_n_skid #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               flush,
    output logic [1:0]         count
`ifdef MUX_N_SKID_SEL_CHECK_EN
    ,
    output logic               sel_err
`endif
);

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] h_data_q, h_data_d, t_data_q, t_data_d;
    logic [SEL_W-1:0] h_sel_q, h_sel_d, t_sel_q, t_sel_d;
    logic [WIDTH-1:0] sel_data;
    logic             push, pop;

    // Out-of-range selects match no input and fall through to zero.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (int'(in_sel) == k) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = h_data_q;
    assign out_sel   = h_sel_q;
    assign count     = count_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_d  = count_q;
        h_data_d = h_data_q;
        h_sel_d  = h_sel_q;
        t_data_d = t_data_q;
        t_sel_d  = t_sel_q;
        if (flush) begin
            count_d  = 2'd0;
            h_data_d = '0;
            h_sel_d  = '0;
            t_data_d = '0;
            t_sel_d  = '0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        h_data_d = sel_data;
                        h_sel_d  = in_sel;
                        count_d  = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        h_data_d = sel_data;
                        h_sel_d  = in_sel;
                    end else if (push) begin
                        t_data_d = sel_data;
                        t_sel_d  = in_sel;
                        count_d  = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        h_data_d = t_data_q;
                        h_sel_d  = t_sel_q;
                        count_d  = 2'd1;
                    end
                end
                default: count_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q  <= 2'd0;
            h_data_q <= '0;
            h_sel_q  <= '0;
            t_data_q <= '0;
            t_sel_q  <= '0;
        end else begin
            count_q  <= count_d;
            h_data_q <= h_data_d;
            h_sel_q  <= h_sel_d;
            t_data_q <= t_data_d;
            t_sel_q  <= t_sel_d;
        end
    end

`ifdef MUX_N_SKID_SEL_CHECK_EN
    logic sel_err_q, sel_err_d;

    // Sticky until reset; a push discarded by flush still counts as a bad select.
    always_comb begin
        sel_err_d = sel_err_q;
        if (push && (int'(in_sel) >= int'(N))) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_n_skid.sv
// Directed self-checking bench for mux_n_skid: an N=4 instance for the datapath and an N=3
// instance for out-of-range selects.
module tb_mux_n_skid;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // N=4 instance
    logic [127:0] in_data4;
    logic [1:0]   in_sel4;
    logic         in_valid4, in_ready4, out_valid4, out_ready4, flush4;
    logic [31:0]  out_data4;
    logic [1:0]   out_sel4;
    logic [1:0]   count4;
`ifdef MUX_N_SKID_SEL_CHECK_EN
    logic         sel_err4;
`endif

    // N=3 instance
    logic [95:0]  in_data3;
    logic [1:0]   in_sel3;
    logic         in_valid3, in_ready3, out_valid3, out_ready3, flush3;
    logic [31:0]  out_data3;
    logic [1:0]   out_sel3;
    logic [1:0]   count3;
`ifdef MUX_N_SKID_SEL_CHECK_EN
    logic         sel_err3;
`endif

    mux_n_skid #(.WIDTH(32), .N(4)) u_dut4 (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data4),
        .in_sel    (in_sel4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .out_data  (out_data4),
        .out_sel   (out_sel4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .flush     (flush4),
        .count     (count4)
`ifdef MUX_N_SKID_SEL_CHECK_EN
        ,
        .sel_err   (sel_err4)
`endif
    );

    mux_n_skid #(.WIDTH(32), .N(3)) u_dut3 (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data3),
        .in_sel    (in_sel3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .flush     (flush3),
        .count     (count3)
`ifdef MUX_N_SKID_SEL_CHECK_EN
        ,
        .sel_err   (sel_err3)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge and are sampled by the DUT on the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input logic [1:0] cnt, input logic [31:0] dat,
                        input logic [1:0] sel);
        check_eq({tag, ".count"}, 32'(count4), 32'(cnt));
        check_eq({tag, ".out_valid"}, 32'(out_valid4), 32'(cnt != 2'd0));
        check_eq({tag, ".in_ready"}, 32'(in_ready4), 32'(cnt != 2'd2));
        check_eq({tag, ".out_data"}, out_data4, dat);
        check_eq({tag, ".out_sel"}, 32'(out_sel4), 32'(sel));
    endtask

    initial begin
        rstn       = 1'b0;
        in_data4   = {32'h44, 32'h33, 32'h22, 32'h11};
        in_sel4    = 2'd0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        flush4     = 1'b0;
        in_data3   = {32'h33, 32'h22, 32'h11};
        in_sel3    = 2'd0;
        in_valid3  = 1'b0;
        out_ready3 = 1'b0;
        flush3     = 1'b0;

        // Reset and single transfer
        step();
        step();
        chk4("reset", 2'd0, 32'h0, 2'd0);
        rstn      = 1'b1;
        in_valid4 = 1'b1;
        in_sel4   = 2'd2;
        out_ready4 = 1'b1;
        step();
        chk4("single", 2'd1, 32'h33, 2'd2);
        in_valid4 = 1'b0;
        step();
        chk4("single_pop_hold", 2'd0, 32'h33, 2'd2);

        // Backpressure and fill
        out_ready4 = 1'b0;
        in_valid4  = 1'b1;
        in_sel4    = 2'd0;
        step();
        chk4("fill1", 2'd1, 32'h11, 2'd0);
        in_sel4 = 2'd3;
        step();
        chk4("fill2", 2'd2, 32'h11, 2'd0);
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        step();
        chk4("drain1", 2'd1, 32'h44, 2'd3);
        step();
        chk4("drain2", 2'd0, 32'h44, 2'd3);

        // Streaming at one transfer per cycle
        in_valid4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_sel4 = 2'(i);
            step();
            chk4($sformatf("stream%0d", i), 2'd1, 32'h11 * 32'(i + 1), 2'(i));
        end
        in_valid4 = 1'b0;
        step();
        chk4("stream_end", 2'd0, 32'h44, 2'd3);

        // Flush with simultaneous push
        out_ready4 = 1'b0;
        in_valid4  = 1'b1;
        in_sel4    = 2'd1;
        step();
        in_sel4 = 2'd2;
        step();
        chk4("pre_flush", 2'd2, 32'h22, 2'd1);
        flush4  = 1'b1;
        in_sel4 = 2'd3;
        step();
        chk4("flush", 2'd0, 32'h0, 2'd0);
        flush4    = 1'b0;
        in_valid4 = 1'b0;
        step();
        chk4("post_flush", 2'd0, 32'h0, 2'd0);

        // Mid-operation reset
        in_valid4 = 1'b1;
        in_sel4   = 2'd1;
        step();
        in_sel4 = 2'd2;
        step();
        chk4("pre_reset", 2'd2, 32'h22, 2'd1);
        in_valid4 = 1'b0;
        rstn      = 1'b0;
        step();
        chk4("mid_reset", 2'd0, 32'h0, 2'd0);
        rstn = 1'b1;
        step();

        // Out-of-range select on the N=3 instance
        in_valid3 = 1'b1;
        in_sel3   = 2'd1;
        out_ready3 = 1'b1;
        step();
        check_eq("n3_inrange.out_data", out_data3, 32'h22);
        check_eq("n3_inrange.count", 32'(count3), 32'd1);
`ifdef MUX_N_SKID_SEL_CHECK_EN
        check_eq("n3_inrange.sel_err", 32'(sel_err3), 32'd0);
`endif
        in_sel3 = 2'd3;
        step();
        check_eq("n3_oob.out_data", out_data3, 32'h0);
        check_eq("n3_oob.out_sel", 32'(out_sel3), 32'd3);
        check_eq("n3_oob.out_valid", 32'(out_valid3), 32'd1);
`ifdef MUX_N_SKID_SEL_CHECK_EN
        check_eq("n3_oob.sel_err", 32'(sel_err3), 32'd1);
`endif
        in_valid3 = 1'b0;
        flush3    = 1'b1;
        step();
        flush3 = 1'b0;
        check_eq("n3_flush.count", 32'(count3), 32'd0);
`ifdef MUX_N_SKID_SEL_CHECK_EN
        check_eq("n3_flush.sel_err", 32'(sel_err3), 32'd1);
`endif
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check_eq("n3_reset.count", 32'(count3), 32'd0);
`ifdef MUX_N_SKID_SEL_CHECK_EN
        check_eq("n3_reset.sel_err", 32'(sel_err3), 32'd0);
        check_eq("n4_sel_err", 32'(sel_err4), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
